// File: rtl/next_pc_gen.sv
// Next-PC generator feeding the PC register: sequential, branch, jump and jr redirects with stall.
// Define DELAY_SLOT_EN to build the MIPS delay slot (SLOT state plus pending target register).
module next_pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] currPC,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] nextPC,
  output logic        redirect_pending,
  output logic        addr_err
);

  // state | meaning
  // SEQ   | sequential fetch, redirect requests accepted
  // SLOT  | delay-slot instruction issued; pending target goes out next

  logic [31:0] seq_pc;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] sel_tgt;
  logic        req;
  logic        misalign;
  logic [31:0] next_pc;
  logic        addr_err_d;
  logic        addr_err_q;

  always_comb begin
    seq_pc   = currPC + PC_STEP;
    br_tgt   = currPC + 32'd4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    j_tgt    = {seq_pc[31:28], jump_index, 2'b00};
    jr_tgt   = {jr_addr[31:2], 2'b00};
    req      = jr | jump | branch;
    misalign = jr & (jr_addr[1:0] != 2'b00);
    if (jr) begin
      sel_tgt = jr_tgt;
    end else if (jump) begin
      sel_tgt = j_tgt;
    end else begin
      sel_tgt = br_tgt;
    end
  end

`ifdef DELAY_SLOT_EN
  typedef enum logic {SEQ, SLOT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    addr_err_d = 1'b0;
    next_pc    = seq_pc;
    if (reset) begin
      next_pc = RESET_VECTOR;
    end else if (stall) begin
      next_pc = currPC;
    end else if (state_q == SLOT) begin
      // requests seen while in the slot are deliberately ignored
      next_pc = pend_q;
      state_d = SEQ;
    end else if (req) begin
      next_pc    = seq_pc;
      pend_d     = sel_tgt;
      state_d    = SLOT;
      addr_err_d = misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEQ;
      pend_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign redirect_pending = (state_q == SLOT) & ~reset;
`else
  always_comb begin
    addr_err_d = 1'b0;
    next_pc    = seq_pc;
    if (reset) begin
      next_pc = RESET_VECTOR;
    end else if (stall) begin
      next_pc = currPC;
    end else if (req) begin
      next_pc    = sel_tgt;
      addr_err_d = misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign redirect_pending = 1'b0;
`endif

  assign nextPC   = next_pc;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_next_pc_gen.sv
// Bench for next_pc_gen: acts as the PC register, models fetch as a queue of forced PCs,
// and pins that model with hand-computed literals. Works with or without DELAY_SLOT_EN.
module tb_next_pc_gen;
  localparam logic [31:0] RV = 32'h00400000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] currPC;
  logic        stall;
  logic        branch;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] next_pc;
  logic        redirect_pending;
  logic        addr_err;

  next_pc_gen #(.RESET_VECTOR(RV), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .currPC(currPC), .stall(stall),
    .branch(branch), .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_addr(jr_addr), .nextPC(next_pc),
    .redirect_pending(redirect_pending), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // model state (written by the stimulus process at each edge)
  logic [31:0] q_m[$];
  logic        aerr_m = 1'b0;

  // expectations (written by the compare process)
  logic [31:0] e_next = RV;
  logic        e_pend = 1'b0;
  logic        e_clr = 1'b1;
  logic        e_pop = 1'b0;
  logic        e_push = 1'b0;
  logic [31:0] e_tgt = '0;
  logic        e_aerr_n = 1'b0;
  logic [31:0] m_seq, m_bt, m_jt, m_jrt, m_tgt;
  int          m_off;

  // hand-computed literals for the current cycle
  logic        lit_next_en = 1'b0, lit_pend_en = 1'b0, lit_aerr_en = 1'b0;
  logic [31:0] lit_next = '0;
  logic        lit_pend = 1'b0, lit_aerr = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    m_seq  = currPC + 32'd4;
    m_off  = int'($signed(branch_imm)) * 4;
    m_bt   = currPC + 32'd4 + 32'(m_off);
    m_jt   = {m_seq[31:28], jump_index, 2'b00};
    m_jrt  = jr_addr & 32'hFFFF_FFFC;
    m_tgt  = jr ? m_jrt : (jump ? m_jt : m_bt);
    e_clr = 1'b0; e_pop = 1'b0; e_push = 1'b0; e_tgt = '0; e_aerr_n = 1'b0;
    if (reset) begin
      e_next = RV;
      e_clr  = 1'b1;
    end else if (stall) begin
      e_next = currPC;
    end else if (q_m.size() != 0) begin
      e_next = q_m[0];
      e_pop  = 1'b1;
    end else if (jr || jump || branch) begin
      e_aerr_n = jr && (jr_addr[1:0] != 2'b00);
`ifdef DELAY_SLOT_EN
      e_next = m_seq;
      e_push = 1'b1;
      e_tgt  = m_tgt;
`else
      e_next = m_tgt;
`endif
    end else begin
      e_next = m_seq;
    end
    e_pend = !reset && (q_m.size() != 0);

    chk("nextPC", next_pc, e_next);
    chk("redirect_pending", 32'(redirect_pending), 32'(e_pend));
    chk("addr_err", 32'(addr_err), 32'(aerr_m));
    if (lit_next_en) begin
      chk("model_next_lit", e_next, lit_next);
      chk("dut_next_lit", next_pc, lit_next);
    end
    if (lit_pend_en) begin
      chk("model_pend_lit", 32'(e_pend), 32'(lit_pend));
      chk("dut_pend_lit", 32'(redirect_pending), 32'(lit_pend));
    end
    if (lit_aerr_en) begin
      chk("model_aerr_lit", 32'(aerr_m), 32'(lit_aerr));
      chk("dut_aerr_lit", 32'(addr_err), 32'(lit_aerr));
    end
  end

  // let the compare run for the current inputs, then latch the PC register and model state
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
    if (e_clr) q_m.delete();
    else begin
      if (e_pop) void'(q_m.pop_front());
      if (e_push) q_m.push_back(e_tgt);
    end
    aerr_m = e_aerr_n;
    currPC = e_next;
    lit_next_en = 1'b0; lit_pend_en = 1'b0; lit_aerr_en = 1'b0;
  endtask

  task automatic expect_next(input logic [31:0] v);
    lit_next_en = 1'b1; lit_next = v;
  endtask

  task automatic expect_pend(input logic v);
    lit_pend_en = 1'b1; lit_pend = v;
  endtask

  task automatic expect_aerr(input logic v);
    lit_aerr_en = 1'b1; lit_aerr = v;
  endtask

  task automatic drop_reqs();
    branch = 1'b0; jump = 1'b0; jr = 1'b0;
  endtask

  // request already on the inputs; walk it through to the target and the end of addr_err
  task automatic redirect(input logic [31:0] tgt, input logic aerr);
`ifdef DELAY_SLOT_EN
    expect_next(currPC + 32'd4); expect_pend(1'b0);
    tick(); drop_reqs();
    expect_next(tgt); expect_pend(1'b1); expect_aerr(aerr);
    tick();
`else
    expect_next(tgt); expect_pend(1'b0);
    tick(); drop_reqs();
    expect_next(tgt + 32'd4); expect_aerr(aerr);
    tick();
`endif
    expect_aerr(1'b0); expect_pend(1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1; currPC = '0; stall = 1'b0; drop_reqs();
    branch_imm = '0; jump_index = '0; jr_addr = '0;

    // reset then sequential fetch
    repeat (3) begin expect_next(RV); expect_pend(1'b0); tick(); end
    reset = 1'b0;
    expect_next(32'h00400004); expect_aerr(1'b0); tick();
    expect_next(32'h00400008); expect_aerr(1'b0); tick();
    expect_next(32'h0040000C); tick();

    // branch forward, then backward with wrap-around
    currPC = 32'h00000010; branch = 1'b1; branch_imm = 16'h0003;
    redirect(32'h00000020, 1'b0);
    currPC = 32'h00000000; branch = 1'b1; branch_imm = 16'hFFFE;
    redirect(32'hFFFFFFFC, 1'b0);

    // jumps, including one where seq crosses a 256 MB region
    currPC = 32'hA0000100; jump = 1'b1; jump_index = 26'h0000040;
    redirect(32'hA0000100, 1'b0);
    currPC = 32'h0FFFFFFC; jump = 1'b1; jump_index = 26'h0000123;
    redirect(32'h1000048C, 1'b0);

    // priority: jr over jump over branch, misaligned jr flags addr_err
    currPC = 32'h00000200; branch = 1'b1; branch_imm = 16'h0005;
    jump = 1'b1; jump_index = 26'h0000007; jr = 1'b1; jr_addr = 32'h00001003;
    redirect(32'h00001000, 1'b1);
    currPC = 32'h00000300; branch = 1'b1; branch_imm = 16'h0001;
    jump = 1'b1; jump_index = 26'h0000100;
    redirect(32'h00000400, 1'b0);
    currPC = 32'h00000600; jr = 1'b1; jr_addr = 32'h00008000;
    redirect(32'h00008000, 1'b0);

`ifdef DELAY_SLOT_EN
    // stall while in the slot; a branch presented in the slot is ignored
    currPC = 32'h00000040; branch = 1'b1; branch_imm = 16'h0010;
    expect_next(32'h00000044); tick();
    stall = 1'b1; branch = 1'b1; branch_imm = 16'h0007;
    repeat (2) begin expect_next(32'h00000044); expect_pend(1'b1); tick(); end
    stall = 1'b0;
    expect_next(32'h00000084); expect_pend(1'b1); tick();
    drop_reqs();
    expect_next(32'h00000088); expect_pend(1'b0); tick();

    // reset in the slot discards the pending target
    currPC = 32'h00000500; jump = 1'b1; jump_index = 26'h0001000;
    expect_next(32'h00000504); tick();
    drop_reqs(); reset = 1'b1;
    expect_next(RV); expect_pend(1'b0); tick();
    reset = 1'b0;
    expect_next(RV + 32'd4); expect_pend(1'b0); tick();
`else
    // stall drops a request; it is re-presented afterwards
    currPC = 32'h00000040; branch = 1'b1; branch_imm = 16'h0010; stall = 1'b1;
    repeat (2) begin expect_next(32'h00000040); tick(); end
    stall = 1'b0;
    redirect(32'h00000084, 1'b0);

    // reset dominates a pending request
    currPC = 32'h00000500; jump = 1'b1; jump_index = 26'h0001000; reset = 1'b1;
    expect_next(RV); tick();
    drop_reqs(); reset = 1'b0;
    expect_next(RV + 32'd4); tick();
`endif

    // stall dominates a misaligned jr: no redirect, no addr_err
    currPC = 32'h00000700; stall = 1'b1; jr = 1'b1; jr_addr = 32'h00002002;
    expect_next(32'h00000700); tick();
    stall = 1'b0; drop_reqs();
    expect_aerr(1'b0); expect_next(32'h00000704); tick();

    // reset dominates stall
    reset = 1'b1; stall = 1'b1;
    expect_next(RV); tick();
    reset = 1'b0; stall = 1'b0;
    expect_next(RV + 32'd4); expect_aerr(1'b0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/next_pc_gen.md
Name: next_pc_gen

Overview:
- Producer side of the program-counter interface: computes `nextPC` from `currPC` and decoded control-flow requests.
- Its output feeds the PC register, which latches `nextPC` on every rising clock edge; `currPC` feeds back into this block.
- Handles sequential advance, branch, jump and jump-register redirects, stalls, an optional MIPS branch-delay slot, and misaligned-target flagging.

Parameters:
- RESET_VECTOR, 32'h00000000, value driven on `nextPC` while reset is high.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  input  1  rising-edge clock shared with the PC register.
- reset  input  1  synchronous, active-high reset.
- currPC  input  32  current PC from the PC register.
- stall  input  1  hold PC; nextPC = currPC.
- branch  input  1  taken conditional branch at currPC.
- branch_imm  input  16  branch word offset, signed.
- jump  input  1  J/JAL at currPC.
- jump_index  input  26  jump instruction index field.
- jr  input  1  JR/JALR at currPC.
- jr_addr  input  32  register target for jr.
- nextPC  output  32  combinational next PC to the PC register.
- redirect_pending  output  1  high while state = SLOT.
- addr_err  output  1  registered one-cycle pulse for a misaligned redirect target.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on port `reset`.
- Reset state: while reset = 1, `nextPC` = RESET_VECTOR (combinational override); state <= SEQ; pending target <= 0; addr_err <= 0; redirect_pending = 0. Reset mid-SLOT discards the pending target.
- Sequential target: seq = currPC + PC_STEP, mod 2^32.
- Branch target: bt = currPC + 4 + (sign-extended branch_imm << 2), mod 2^32. Wrap-around is allowed, e.g. currPC = 0, imm = 16'hFFFE gives 32'hFFFFFFFC.
- Jump target: jt = {seq[31:28], jump_index, 2'b00}.
- JR target: jr_addr with bits [1:0] forced to 0.
- Request priority when several are asserted together: jr > jump > branch. The losers are ignored.
- Target commit: the selected target is registered (or applied) on the accepting edge.
- Misaligned target: if jr is selected and jr_addr[1:0] != 0, addr_err = 1 for exactly the cycle after the accepting edge. The redirect still proceeds to the aligned address.
- Stall: stall = 1 gives nextPC = currPC. No state change, no capture; requests are dropped and the decoder re-presents them. Stall dominates all requests. Reset dominates stall.
- FSM, two states SEQ and SLOT (SLOT exists only with DELAY_SLOT_EN).
  - SEQ: no request -> nextPC = seq.
  - SEQ with a request, with DELAY_SLOT_EN: nextPC = seq (the delay slot). Capture the target into the pending register; next state SLOT.
  - SEQ with a request, without DELAY_SLOT_EN: nextPC = target immediately; stay in SEQ.
  - SLOT: nextPC = pending target. branch, jump and jr are ignored (control flow in a delay slot is unsupported). On a non-stalled edge go to SEQ. If stalled, nextPC = currPC and the block stays in SLOT with the pending target held.
- Latency, with DELAY_SLOT_EN: the redirect appears on currPC two edges after the request edge. Without it: one edge.
- Registers: state, pending target (32), addr_err. All outputs other than addr_err are combinational from inputs and state.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: MIPS architectural delay slot. Every accepted redirect executes the instruction at currPC+4 first, via the SLOT state and pending register.
- Undefined: redirect is immediate. SLOT state and pending register are not built; redirect_pending is tied to 0.

Test Plan:
- Reset: hold reset 3 cycles with RESET_VECTOR = 32'h00400000, then release -> currPC = 32'h00400000, then 32'h00400004 and 32'h00400008 on successive edges; addr_err = 0 throughout.
- Branch with DELAY_SLOT_EN: currPC = 32'h00000010, branch = 1, imm = 16'h0003 -> nextPC = 32'h00000014 with redirect_pending = 1 next cycle. Then nextPC = 32'h00000020. Then the sequence resumes at 32'h00000024.
- Jump without DELAY_SLOT_EN: currPC = 32'hA0000100, jump = 1, index = 26'h0000040 -> nextPC = 32'hA0000100 on the same cycle. Check jt = {4'hA, 26'h0000040, 2'b00}.
- Priority plus misalignment: branch, jump and jr asserted together, jr_addr = 32'h00001003 -> target 32'h00001000 taken; addr_err pulses exactly one cycle.
- Stall in SLOT: stall for 2 cycles while redirect_pending = 1 -> currPC frozen at the slot address, pending target retained; redirect completes on the first unstalled edge. A branch asserted in SLOT is ignored.
- Reset mid-SLOT: assert reset while redirect_pending = 1 -> next currPC = RESET_VECTOR, redirect_pending = 0; the pending target never appears.
